// File: rtl/k2red_pkg.sv
// Shared types and defaults for the K^2-RED unscaler.
package k2red_pkg;

  localparam int unsigned W_DEF  = 32;
  localparam int unsigned MW_DEF = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  // Doubling counter must hold 2*m, i.e. one bit wider than m.
  function automatic int unsigned cnt_width(input int unsigned mw);
    return mw + 1;
  endfunction

endpackage

// File: rtl/mod_dbl.sv
// Combinational modular doubling: y = (2x >= q) ? 2x - q : 2x, for x < q.
module mod_dbl #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] x,
  input  logic [W-1:0] q,
  output logic [W-1:0] y
);

  logic [W:0] sum;
  logic [W:0] q_ext;

  always_comb begin
    sum   = {x, 1'b0};
    q_ext = {1'b0, q};
    y     = (sum >= q_ext) ? W'(sum - q_ext) : W'(sum);
  end

endmodule

// File: rtl/k2red_unscale_m.sv
// Removes the k^2 factor from a K^2-RED result: R = C * 2^(2m) mod Q via 2m modular doublings.
module k2red_unscale_m
  import k2red_pkg::*;
#(
  parameter int unsigned W  = W_DEF,
  parameter int unsigned MW = MW_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [W-1:0]  C,
  input  logic [W-1:0]  Q,
  input  logic [MW-1:0] m,
  output logic          busy,
  output logic          done,
  output logic [W-1:0]  R
);

  localparam int unsigned CW = cnt_width(MW);

  state_e        state_q, state_d;
  logic [W-1:0]  x_q, x_d;
  logic [W-1:0]  qr_q, qr_d;
  logic [W-1:0]  r_q, r_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [W-1:0]  c_pc;
  logic [W-1:0]  x_dbl;

  mod_dbl #(.W(W)) u_mod_dbl (
    .x (x_q),
    .q (qr_q),
    .y (x_dbl)
  );

  // Single conditional subtract brings C < 2Q into [0, Q-1].
  always_comb begin
    c_pc = (C >= Q) ? (C - Q) : C;
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    qr_d    = qr_q;
    r_d     = r_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          qr_d    = Q;
          x_d     = c_pc;
          cnt_d   = {m, 1'b0};
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != CW'(0)) begin
          x_d   = x_dbl;
          cnt_d = cnt_q - CW'(1);
        end else begin
          r_d     = x_q;
          done_d  = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      qr_q    <= '0;
      r_q     <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      qr_q    <= qr_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign R    = r_q;

endmodule

// File: tb/tb_k2red_unscale_m.sv
// Directed bench for k2red_unscale_m: results, latency, start filtering and mid-job reset.
module tb_k2red_unscale_m;

  localparam logic [31:0] QB = 32'd2147352577;  // 16383*2^17 + 1

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] c_i;
  logic [31:0] q_i;
  logic [5:0]  m_i;
  logic        busy;
  logic        done;
  logic [31:0] r_o;

  int total;
  int bad;

  k2red_unscale_m #(.W(32), .MW(6)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .C     (c_i),
    .Q     (q_i),
    .m     (m_i),
    .busy  (busy),
    .done  (done),
    .R     (r_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse start for one cycle and wait (bounded) for done; lat counts cycles from the start cycle.
  task automatic run_job(input logic [31:0] c, input logic [31:0] q, input logic [5:0] mm,
                         output logic [31:0] r, output int lat, output int busy_err);
    @(negedge clk);
    c_i = c; q_i = q; m_i = mm; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    lat = -1; busy_err = 0; r = 32'hdead_beef;
    for (int cyc = 1; cyc <= 300; cyc++) begin
      if (done) begin
        lat = cyc; r = r_o;
        if (!busy) busy_err++;
        break;
      end
      if (!busy) busy_err++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; c_i = '0; q_i = '0; m_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || r_o !== 32'd0) begin
      bad++;
      $display("FAIL reset_state: busy=%b done=%b R=%0d required 0 0 0", busy, done, r_o);
    end
  endtask

  task automatic test_main_timing();
    logic [31:0] r; int lat; int be;
    run_job(32'd1, QB, 6'd17, r, lat, be);
    total++;
    if (r !== 32'd1048568) begin bad++; $display("FAIL m17_c1_result: got %0d required 1048568", r); end
    total++;
    if (lat !== 36) begin bad++; $display("FAIL m17_latency: got %0d required 36", lat); end
    total++;
    if (be !== 0) begin bad++; $display("FAIL m17_busy_window: %0d cycles low, required 0", be); end
    @(negedge clk);
    total++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL m17_done_fall: done=%b busy=%b required 0 0", done, busy);
    end
    total++;
    if (r_o !== 32'd1048568) begin bad++; $display("FAIL m17_r_held: got %0d required 1048568", r_o); end
  endtask

  task automatic test_precorrect();
    logic [31:0] r; int lat; int be;
    run_job(QB, QB, 6'd17, r, lat, be);
    total++;
    if (r !== 32'd0) begin bad++; $display("FAIL c_eq_q: got %0d required 0", r); end
    run_job(QB + 32'd1, QB, 6'd17, r, lat, be);
    total++;
    if (r !== 32'd1048568) begin bad++; $display("FAIL c_eq_q_plus1: got %0d required 1048568", r); end
  endtask

  task automatic test_small_q();
    logic [31:0] r; int lat; int be;
    run_job(32'd1, 32'd13, 6'd2, r, lat, be);
    total++;
    if (r !== 32'd3) begin bad++; $display("FAIL q13_c1: got %0d required 3", r); end
    total++;
    if (lat !== 6) begin bad++; $display("FAIL q13_latency: got %0d required 6", lat); end
    run_job(32'd5, 32'd13, 6'd2, r, lat, be);
    total++;
    if (r !== 32'd2) begin bad++; $display("FAIL q13_c5: got %0d required 2", r); end
    total++;
    if (((r * 32'd9) % 32'd13) !== 32'd5) begin
      bad++; $display("FAIL q13_round_trip: got %0d required 5", (r * 32'd9) % 32'd13);
    end
    run_job(32'd14, 32'd13, 6'd2, r, lat, be);
    total++;
    if (r !== 32'd3) begin bad++; $display("FAIL q13_c14: got %0d required 3", r); end
    run_job(32'd50, 32'd97, 6'd5, r, lat, be);
    total++;
    if (r !== 32'd81) begin bad++; $display("FAIL q97_c50: got %0d required 81", r); end
    run_job(32'd150, 32'd97, 6'd5, r, lat, be);
    total++;
    if (r !== 32'd49) begin bad++; $display("FAIL q97_c150: got %0d required 49", r); end
  endtask

  task automatic test_m_zero();
    logic [31:0] r; int lat; int be;
    run_job(32'd12, 32'd7, 6'd0, r, lat, be);
    total++;
    if (r !== 32'd5) begin bad++; $display("FAIL m0_result: got %0d required 5", r); end
    total++;
    if (lat !== 2) begin bad++; $display("FAIL m0_latency: got %0d required 2", lat); end
  endtask

  task automatic test_back_to_back();
    int dones; int lat;
    @(negedge clk);
    c_i = 32'd1; q_i = 32'd13; m_i = 6'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0; lat = -1;
    // Disturb inputs and pulse start during SHIFT; Q/m must stay latched.
    @(negedge clk);
    c_i = 32'd5; q_i = 32'd7; m_i = 6'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int cyc = 3; cyc <= 40; cyc++) begin
      if (done) begin lat = cyc; break; end
      @(negedge clk);
    end
    total++;
    if (lat !== 6 || r_o !== 32'd3) begin
      bad++; $display("FAIL b2b_first: lat=%0d R=%0d required 6 3", lat, r_o);
    end
    // Start during DONE must be dropped; held into the next IDLE cycle it is accepted.
    c_i = 32'd5; q_i = 32'd13; m_i = 6'd2; start = 1'b1;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL b2b_done_start_ignored: busy=%b done=%b required 0 0", busy, done);
    end
    @(negedge clk);
    start = 1'b0;
    lat = -1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin dones++; if (lat < 0) lat = cyc; end
      @(negedge clk);
    end
    total++;
    if (lat !== 6 || dones !== 1 || r_o !== 32'd2) begin
      bad++; $display("FAIL b2b_second: lat=%0d dones=%0d R=%0d required 6 1 2", lat, dones, r_o);
    end
  endtask

  task automatic test_mid_reset();
    int dones; logic [31:0] r; int lat; int be;
    @(negedge clk);
    c_i = 32'd1; q_i = QB; m_i = 6'd17; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1; start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    total++;
    if (busy !== 1'b0 || done !== 1'b0 || r_o !== 32'd0) begin
      bad++; $display("FAIL midreset_state: busy=%b done=%b R=%0d required 0 0 0", busy, done, r_o);
    end
    dones = 0;
    for (int cyc = 0; cyc < 50; cyc++) begin
      if (done || busy) dones++;
      @(negedge clk);
    end
    total++;
    if (dones !== 0) begin bad++; $display("FAIL midreset_quiet: %0d active cycles required 0", dones); end
    run_job(QB + 32'd1, QB, 6'd17, r, lat, be);
    total++;
    if (r !== 32'd1048568 || lat !== 36) begin
      bad++; $display("FAIL midreset_restart: R=%0d lat=%0d required 1048568 36", r, lat);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst = 1'b1; start = 1'b0; c_i = '0; q_i = '0; m_i = '0;
    test_reset();
    test_main_timing();
    test_precorrect();
    test_small_q();
    test_m_zero();
    test_back_to_back();
    test_mid_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
